// File: rtl/wb_check_pkg.sv
// Shared types for the writeback stream checker: FSM states, table entry and exp_n clamp.
package wb_check_pkg;

  // Entry fields are sized for the widest supported core; narrower ports are zero-extended.
  localparam int unsigned WB_RA_W_MAX = 8;
  localparam int unsigned WB_XLEN_MAX = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TMO
  } wb_chk_state_t;

  typedef struct packed {
    logic [WB_RA_W_MAX-1:0] a;
    logic [WB_XLEN_MAX-1:0] d;
  } wb_entry_t;

  function automatic int unsigned clamp_n(input int unsigned n, input int unsigned depth);
    return (n > depth) ? depth : n;
  endfunction

endpackage

// File: rtl/wb_check_table.sv
// Expected-entry table: one synchronous write port, one combinational read port, no reset.
module wb_check_table
  import wb_check_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [IW-1:0] i_widx,
  input  wb_entry_t     i_wdata,
  input  logic [IW-1:0] i_ridx,
  output wb_entry_t     o_rdata
);

  wb_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_widx] <= i_wdata;
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/wb_stream_checker.sv
// Order-based checker for the core writeback port against a loadable expected table.
// Optional: define WB_CHECK_IGNORE_X0_EN to treat writebacks to x0 as idle cycles.
module wb_stream_checker
  import wb_check_pkg::*;
#(
  parameter  int unsigned XLEN    = 32,
  parameter  int unsigned RA_W    = 5,
  parameter  int unsigned DEPTH   = 16,
  parameter  int unsigned TIMEOUT = 32,
  localparam int unsigned IW      = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            exp_we,
  input  logic [IW-1:0]   exp_idx,
  input  logic [RA_W-1:0] exp_a,
  input  logic [XLEN-1:0] exp_d,
  input  logic [IW:0]     exp_n,
  input  logic            start,
  input  logic            wb_e,
  input  logic [RA_W-1:0] wb_a,
  input  logic [XLEN-1:0] wb_d,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [IW:0]     err_idx,
  output logic [RA_W-1:0] err_a,
  output logic [XLEN-1:0] err_d,
  output logic [IW:0]     match_cnt
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  wb_chk_state_t   r_state, w_next;
  logic [IW:0]     r_n, r_ptr, r_match, r_err_idx;
  logic [RA_W-1:0] r_err_a;
  logic [XLEN-1:0] r_err_d;
  logic [TW-1:0]   r_idle;

  logic            w_run, w_arm, w_ev, w_hit, w_last, w_tmo;
  logic [IW:0]     w_n_clamp;
  wb_entry_t       w_exp_e, w_wb_e, w_rd_e;

  assign w_run     = (r_state == ST_RUN);
  assign w_arm     = start && !w_run;
  assign w_n_clamp = (IW+1)'(clamp_n(32'(exp_n), DEPTH));

  assign w_exp_e = '{a: WB_RA_W_MAX'(exp_a), d: WB_XLEN_MAX'(exp_d)};
  assign w_wb_e  = '{a: WB_RA_W_MAX'(wb_a),  d: WB_XLEN_MAX'(wb_d)};

  wb_check_table #(.DEPTH(DEPTH)) u_table (
    .clk     (clk),
    .i_we    (exp_we && !w_run),
    .i_widx  (exp_idx),
    .i_wdata (w_exp_e),
    .i_ridx  (r_ptr[IW-1:0]),
    .o_rdata (w_rd_e)
  );

`ifdef WB_CHECK_IGNORE_X0_EN
  assign w_ev = wb_e && (wb_a != '0);
`else
  assign w_ev = wb_e;
`endif

  assign w_hit  = (w_wb_e == w_rd_e);
  assign w_last = (r_ptr == r_n - (IW+1)'(1));
  assign w_tmo  = (TIMEOUT != 0) && (r_idle == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_run) begin
      if (w_ev)       w_next = w_hit ? (w_last ? ST_PASS : ST_RUN) : ST_FAIL;
      else if (w_tmo) w_next = ST_TMO;
    end else if (start) begin
      w_next = (w_n_clamp == '0) ? ST_PASS : ST_RUN;
    end
  end

  always_comb begin
    busy = (r_state == ST_RUN);
    done = (r_state == ST_PASS) || (r_state == ST_FAIL) || (r_state == ST_TMO);
    pass = (r_state == ST_PASS);
  end

  always_ff @(posedge clk) begin
    if (reset || w_arm) begin
      r_n       <= reset ? '0 : w_n_clamp;
      r_ptr     <= '0;
      r_match   <= '0;
      r_idle    <= '0;
      r_err_idx <= '0;
      r_err_a   <= '0;
      r_err_d   <= '0;
    end else if (w_run) begin
      if (w_ev) begin
        if (w_hit) begin
          r_ptr   <= r_ptr + (IW+1)'(1);
          r_match <= r_match + (IW+1)'(1);
          r_idle  <= '0;
        end else begin
          r_err_idx <= r_ptr;
          r_err_a   <= wb_a;
          r_err_d   <= wb_d;
        end
      end else if (TIMEOUT != 0) begin
        r_idle <= r_idle + TW'(1);
        if (w_tmo) begin
          r_err_idx <= r_ptr;
          r_err_a   <= '0;
          r_err_d   <= '0;
        end
      end
    end
  end

  assign err_idx   = r_err_idx;
  assign err_a     = r_err_a;
  assign err_d     = r_err_d;
  assign match_cnt = r_match;

endmodule
